// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage. Memory ops go out on a request/ack data bus.
// Loads are sign- or zero-extended into the writeback path. All other
// EX/MEM fields pass straight through to MEM/WB.
module mem_access (
   input  logic        clk,
   input  logic        rst,
   // EX/MEM side
   input  logic [4:0]  ex_wd,
   input  logic        ex_wreg,
   input  logic [31:0] ex_wdata,
   input  logic        ex_whilo,
   input  logic [31:0] ex_hi,
   input  logic [31:0] ex_lo,
   input  logic [3:0]  ex_mem_op,
   input  logic [31:0] ex_mem_addr,
   input  logic [31:0] ex_mem_data,
   // MEM/WB side
   output logic [4:0]  mem_wd,
   output logic        mem_wreg,
   output logic [31:0] mem_wdata,
   output logic        mem_whilo,
   output logic [31:0] mem_hi,
   output logic [31:0] mem_lo,
   // pipeline control
   input  logic [5:0]  stall,
   input  logic        flush,
   output logic        stallreq,
   // data bus
   output logic        dreq,
   output logic        dwe,
   output logic [3:0]  dbe,
   output logic [31:0] daddr,
   output logic [31:0] dwdata,
   input  logic        dack,
   input  logic [31:0] drdata,
   // address exceptions
   output logic        excpt_adel,
   output logic        excpt_ades
);

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_LB   = 4'd1;
   localparam logic [3:0] OP_LBU  = 4'd2;
   localparam logic [3:0] OP_LH   = 4'd3;
   localparam logic [3:0] OP_LHU  = 4'd4;
   localparam logic [3:0] OP_LW   = 4'd5;
   localparam logic [3:0] OP_SB   = 4'd6;
   localparam logic [3:0] OP_SH   = 4'd7;
   localparam logic [3:0] OP_SW   = 4'd8;

   localparam int STALL_MEM = 3;   // MEM-stage bit of the stall vector

   typedef enum logic [1:0] {
      S_IDLE,    // no transaction outstanding
      S_REQ,     // request on the bus, waiting for dack
      S_DONE,    // load data captured, waiting for the pipeline to advance
      S_ABORT    // flushed mid-request, draining the ack
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  op_q;
   logic [31:0] addr_q;
   logic [3:0]  be_q,    be_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q;
   logic [31:0] lbuf_q;

   logic is_load, is_store, is_mem, misaligned, go;
   logic issue, capture;

   // Only the MEM-stage stall bit matters to this stage.
   logic unused_stall;
   assign unused_stall = ^{stall[5:4], stall[2:0]};

   // Extract a load result from the captured bus word (little-endian lanes).
   function automatic logic [31:0] extract_load(input logic [3:0]  op,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
      logic [31:0] shifted;
      logic [7:0]  b;
      logic [15:0] h;
      shifted = word >> {off, 3'b000};
      b       = shifted[7:0];
      h       = off[1] ? word[31:16] : word[15:0];
      case (op)
         OP_LB:   extract_load = {{24{b[7]}}, b};
         OP_LBU:  extract_load = {24'h000000, b};
         OP_LH:   extract_load = {{16{h[15]}}, h};
         OP_LHU:  extract_load = {16'h0000, h};
         default: extract_load = word;
      endcase
   endfunction

   // Decode the op class and the alignment fault for the current op.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      is_load    = 1'b0;
      is_store   = 1'b0;
      misaligned = 1'b0;
      case (ex_mem_op)
         OP_LB, OP_LBU: is_load = 1'b1;
         OP_LH, OP_LHU: begin
            is_load    = 1'b1;
            misaligned = ex_mem_addr[0];
         end
         OP_LW: begin
            is_load    = 1'b1;
            misaligned = |ex_mem_addr[1:0];
         end
         OP_SB: is_store = 1'b1;
         OP_SH: begin
            is_store   = 1'b1;
            misaligned = ex_mem_addr[0];
         end
         OP_SW: begin
            is_store   = 1'b1;
            misaligned = |ex_mem_addr[1:0];
         end
         default: ;   // OP_NONE and unused codes
      endcase
   end

   assign is_mem = is_load | is_store;
   assign go     = is_mem & ~misaligned;

   // Form byte enables and lane-replicated store data for a new request.
   always_comb begin
      be_d    = 4'b1111;
      wdata_d = ex_mem_data;
      case (ex_mem_op)
         OP_SB: begin
            be_d    = 4'b0001 << ex_mem_addr[1:0];
            wdata_d = {4{ex_mem_data[7:0]}};
         end
         OP_SH: begin
            be_d    = 4'b0011 << ex_mem_addr[1:0];
            wdata_d = {2{ex_mem_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Next-state logic plus the stall and bus-request outputs.
   always_comb begin
      state_d  = state_q;
      issue    = 1'b0;
      capture  = 1'b0;
      stallreq = 1'b0;
      dreq     = 1'b0;
      case (state_q)
         S_IDLE: begin
            stallreq = go;
            if (go && !flush) begin
               state_d = S_REQ;
               issue   = 1'b1;
            end
         end
         S_REQ: begin
            dreq     = 1'b1;
            stallreq = 1'b1;
            if (dack) begin
               state_d = flush ? S_IDLE : S_DONE;
               capture = ~flush;
            end else if (flush) begin
               state_d = S_ABORT;
            end
         end
         S_DONE: begin
            if (flush || !stall[STALL_MEM]) state_d = S_IDLE;
         end
         S_ABORT: begin
            // The abandoned access still owns the bus; a new op has to wait.
            dreq     = 1'b1;
            stallreq = go;
            if (dack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register, request latch and load buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values together.
         state_q <= S_IDLE;
         op_q    <= OP_NONE;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         lbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         // Latching the request keeps the bus stable through REQ and ABORT
         // even if the EX/MEM fields change underneath (e.g. after a flush).
         if (issue) begin
            op_q    <= ex_mem_op;
            addr_q  <= ex_mem_addr;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= is_store;
         end
         if (capture) lbuf_q <= drdata;
      end
   end

   assign daddr  = {addr_q[31:2], 2'b00};
   assign dwe    = we_q;
   assign dbe    = be_q;
   assign dwdata = wdata_q;

   assign excpt_adel = is_load  & misaligned;
   assign excpt_ades = is_store & misaligned;

   assign mem_wd    = ex_wd;
   assign mem_whilo = ex_whilo;
   assign mem_hi    = ex_hi;
   assign mem_lo    = ex_lo;

   // Writeback data: pass-through, or the extracted load once it has landed.
   always_comb begin
      mem_wreg  = ex_wreg;
      mem_wdata = ex_wdata;
      if (is_mem) begin
         if (misaligned || is_store) begin
            mem_wreg = 1'b0;
         end else if (state_q == S_DONE) begin
            mem_wdata = extract_load(op_q, addr_q[1:0], lbuf_q);
         end else begin
            mem_wreg = 1'b0;   // load still in flight
         end
      end
   end

endmodule
